conv_job_scheduler: RTL and testbench



---
 rtl/conv_job_scheduler.sv | 169 ++++++++++++++++
 tb/tb_conv_job_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_job_scheduler.sv
// Job scheduler for the 3x3 XNOR-convolution engine.
// Queues host jobs, kicks the engine and relocates its local addresses.
module conv_job_scheduler #(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 12,
  parameter int ID_W    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset_b,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ID_W-1:0]   cmd_id,
  input  logic [ADDR_W-1:0] cmd_in_base,
  input  logic [ADDR_W-1:0] cmd_out_base,
  input  logic [ADDR_W-1:0] cmd_w_base,
  output logic              eng_run,
  input  logic              eng_busy,
  input  logic [ADDR_W-1:0] eng_rd_addr,
  input  logic [ADDR_W-1:0] eng_wr_addr,
  input  logic              eng_wr_en,
  input  logic [ADDR_W-1:0] eng_w_addr,
  output logic [ADDR_W-1:0] sram_rd_addr,
  output logic [ADDR_W-1:0] sram_wr_addr,
  output logic              sram_wr_en,
  output logic [ADDR_W-1:0] wmem_rd_addr,
  output logic              done_valid,
  input  logic              done_ready,
  output logic [ID_W-1:0]   done_id,
  output logic              done_err,
  output logic              sched_idle,
  output logic [7:0]        jobs_done
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam int I_IDLE = 0;
  localparam int I_ARM  = 1;
  localparam int I_KICK = 2;
  localparam int I_WAIT = 3;
  localparam int I_RUN  = 4;
  localparam int I_RPT  = 5;

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_ARM  = 6'b000010;
  localparam logic [5:0] S_KICK = 6'b000100;
  localparam logic [5:0] S_WAIT = 6'b001000;
  localparam logic [5:0] S_RUN  = 6'b010000;
  localparam logic [5:0] S_RPT  = 6'b100000;

  logic [ID_W-1:0]   q_id  [DEPTH];
  logic [ADDR_W-1:0] q_in  [DEPTH];
  logic [ADDR_W-1:0] q_out [DEPTH];
  logic [ADDR_W-1:0] q_w   [DEPTH];

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  logic [5:0]        state;
  logic [5:0]        nxt;
  logic [TW-1:0]     tcnt;
  logic              tmo_hit;

  logic [ID_W-1:0]   act_id;
  logic [ADDR_W-1:0] act_in_base;
  logic [ADDR_W-1:0] act_out_base;
  logic [ADDR_W-1:0] act_w_base;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = state[I_ARM];

  // Last WAIT cycle: the counter would reach TIMEOUT on this edge.
  assign tmo_hit = (tcnt == TW'(TIMEOUT - 1));

  assign done_valid = state[I_RPT];
  assign sched_idle = state[I_IDLE] & empty;

  assign sram_rd_addr = eng_rd_addr + act_in_base;
  assign sram_wr_addr = eng_wr_addr + act_out_base;
  assign wmem_rd_addr = eng_w_addr + act_w_base;
  assign sram_wr_en   = eng_wr_en & (state[I_WAIT] | state[I_RUN]);

  always_comb begin
    nxt = state;
    unique case (1'b1)
      state[I_IDLE]: if (!empty) nxt = S_ARM;
      state[I_ARM]:  nxt = S_KICK;
      state[I_KICK]: nxt = S_WAIT;
      state[I_WAIT]: begin
        if (eng_busy)     nxt = S_RUN;
        else if (tmo_hit) nxt = S_RPT;
      end
      state[I_RUN]:  if (!eng_busy) nxt = S_RPT;
      state[I_RPT]:  if (done_ready) nxt = S_IDLE;
      default:       nxt = S_IDLE;
    endcase
  end

  // Queue storage carries no reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (push) begin
      q_id[wr_ptr]  <= cmd_id;
      q_in[wr_ptr]  <= cmd_in_base;
      q_out[wr_ptr] <= cmd_out_base;
      q_w[wr_ptr]   <= cmd_w_base;
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state        <= S_IDLE;
      eng_run      <= 1'b0;
      tcnt         <= '0;
      act_id       <= '0;
      act_in_base  <= '0;
      act_out_base <= '0;
      act_w_base   <= '0;
      done_id      <= '0;
      done_err     <= 1'b0;
      jobs_done    <= '0;
    end else begin
      state   <= nxt;
      eng_run <= state[I_ARM];
      if (state[I_ARM]) begin
        act_id       <= q_id[rd_ptr];
        act_in_base  <= q_in[rd_ptr];
        act_out_base <= q_out[rd_ptr];
        act_w_base   <= q_w[rd_ptr];
      end
      if (state[I_KICK])
        tcnt <= '0;
      else if (state[I_WAIT] && !eng_busy)
        tcnt <= tcnt + 1'b1;
      if (state[I_WAIT] && !eng_busy && tmo_hit) begin
        done_id  <= act_id;
        done_err <= 1'b1;
      end
      if (state[I_RUN] && !eng_busy) begin
        done_id  <= act_id;
        done_err <= 1'b0;
      end
      if (state[I_RPT] && done_ready && !done_err && jobs_done != 8'hFF)
        jobs_done <= jobs_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_conv_job_scheduler.sv
// Directed bench for conv_job_scheduler.
// The test drives the engine side by hand around each job.
module tb_conv_job_scheduler;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_id;
  logic [11:0] cmd_in_base;
  logic [11:0] cmd_out_base;
  logic [11:0] cmd_w_base;
  logic        eng_run;
  logic        eng_busy;
  logic [11:0] eng_rd_addr;
  logic [11:0] eng_wr_addr;
  logic        eng_wr_en;
  logic [11:0] eng_w_addr;
  logic [11:0] sram_rd_addr;
  logic [11:0] sram_wr_addr;
  logic        sram_wr_en;
  logic [11:0] wmem_rd_addr;
  logic        done_valid;
  logic        done_ready;
  logic [3:0]  done_id;
  logic        done_err;
  logic        sched_idle;
  logic [7:0]  jobs_done;

  int checks = 0;
  int errors = 0;

  conv_job_scheduler dut (
    .clk          (clk),
    .reset_b      (reset_b),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_id       (cmd_id),
    .cmd_in_base  (cmd_in_base),
    .cmd_out_base (cmd_out_base),
    .cmd_w_base   (cmd_w_base),
    .eng_run      (eng_run),
    .eng_busy     (eng_busy),
    .eng_rd_addr  (eng_rd_addr),
    .eng_wr_addr  (eng_wr_addr),
    .eng_wr_en    (eng_wr_en),
    .eng_w_addr   (eng_w_addr),
    .sram_rd_addr (sram_rd_addr),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_en   (sram_wr_en),
    .wmem_rd_addr (wmem_rd_addr),
    .done_valid   (done_valid),
    .done_ready   (done_ready),
    .done_id      (done_id),
    .done_err     (done_err),
    .sched_idle   (sched_idle),
    .jobs_done    (jobs_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [3:0] id, input logic [11:0] ib,
                      input logic [11:0] ob, input logic [11:0] wb);
    cmd_valid    = 1'b1;
    cmd_id       = id;
    cmd_in_base  = ib;
    cmd_out_base = ob;
    cmd_w_base   = wb;
    @(negedge clk);
    cmd_valid    = 1'b0;
  endtask

  task automatic wait_run();
    int n = 0;
    while (eng_run !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("run_seen", 32'(eng_run), 1);
  endtask

  task automatic engine(input int len);
    wait_run();
    @(negedge clk);
    eng_busy = 1'b1;
    repeat (len) @(negedge clk);
    eng_busy = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (done_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", 32'(done_valid), 1);
  endtask

  task automatic wait_done(input int id, input int err);
    wait_valid();
    check("done_id", 32'(done_id), id);
    check("done_err", 32'(done_err), err);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    reset_b = 1'b0; cmd_valid = 1'b0; cmd_id = '0;
    cmd_in_base = '0; cmd_out_base = '0; cmd_w_base = '0;
    eng_busy = 1'b0; eng_rd_addr = '0; eng_wr_addr = '0;
    eng_wr_en = 1'b0; eng_w_addr = '0; done_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 1);
    check("rst_idle", 32'(sched_idle), 1);
    check("rst_run", 32'(eng_run), 0);
    check("rst_dvalid", 32'(done_valid), 0);
    check("rst_jobs", 32'(jobs_done), 0);
    reset_b = 1'b1;
    @(negedge clk);
    eng_wr_en = 1'b1;
    eng_rd_addr = 12'h005;
    #1;
    check("idle_wr_gate", 32'(sram_wr_en), 0);
    check("idle_reloc", 32'(sram_rd_addr), 12'h005);
    eng_wr_en = 1'b0;

    // single job, two cycles from visible push to eng_run
    push(4'd3, 12'h100, 12'h200, 12'h010);
    check("push_vis_idle", 32'(sched_idle), 0);
    check("run_early0", 32'(eng_run), 0);
    @(negedge clk);
    check("run_early1", 32'(eng_run), 0);
    @(negedge clk);
    check("run_pulse", 32'(eng_run), 1);
    eng_wr_en = 1'b1;
    #1;
    check("reloc_rd", 32'(sram_rd_addr), 12'h105);
    check("kick_wr_gate", 32'(sram_wr_en), 0);
    @(negedge clk);
    check("run_one_cycle", 32'(eng_run), 0);
    eng_busy = 1'b1;
    #1;
    check("wait_wr_en", 32'(sram_wr_en), 1);
    repeat (40) @(negedge clk);
    eng_busy = 1'b0;
    eng_wr_en = 1'b0;
    wait_done(3, 0);
    check("jobs_1", 32'(jobs_done), 1);
    check("dvalid_clr", 32'(done_valid), 0);

    // FIFO fill while engine is stalled in RUN
    push(4'd1, 12'h000, 12'h000, 12'h000);
    wait_run();
    @(negedge clk);
    eng_busy = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      cmd_valid = 1'b1;
      cmd_id = 4'(4 + i);
      check("fill_ready", 32'(cmd_ready), (i < 4) ? 1 : 0);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("full_ready", 32'(cmd_ready), 0);
    eng_busy = 1'b0;
    wait_done(1, 0);
    for (int k = 0; k < 4; k++) begin
      engine(3);
      wait_done(4 + k, 0);
    end
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (eng_run !== 1'b0) bad++;
    end
    check("no_fifth_job", bad, 0);
    check("fifo_drained", 32'(sched_idle), 1);
    check("jobs_6", 32'(jobs_done), 6);

    // completion back-pressure with a queued job
    push(4'd9, 12'h000, 12'h000, 12'h000);
    push(4'd10, 12'h000, 12'h000, 12'h000);
    engine(2);
    wait_valid();
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_valid !== 1'b1 || done_id !== 4'd9 ||
          done_err !== 1'b0 || eng_run !== 1'b0) bad++;
    end
    check("rpt_hold_bad", bad, 0);
    wait_done(9, 0);
    engine(2);
    wait_done(10, 0);
    check("jobs_8", 32'(jobs_done), 8);

    // busy never arrives: 15 WAIT cycles then error report
    push(4'd2, 12'h000, 12'h000, 12'h000);
    wait_run();
    n = 0;
    while (done_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("tmo_cycles", n, 16);
    wait_done(2, 1);
    check("jobs_tmo", 32'(jobs_done), 8);

    // busy in the final WAIT cycle still succeeds
    push(4'd11, 12'h000, 12'h000, 12'h000);
    wait_run();
    repeat (15) @(negedge clk);
    eng_busy = 1'b1;
    @(negedge clk);
    check("late_busy_run", 32'(done_valid), 0);
    eng_busy = 1'b0;
    wait_done(11, 0);
    check("jobs_9", 32'(jobs_done), 9);

    // address wrap, then reset in the middle of RUN
    push(4'd12, 12'hFFE, 12'hFF0, 12'hF00);
    wait_run();
    eng_rd_addr = 12'h003;
    eng_wr_addr = 12'h020;
    eng_w_addr  = 12'h100;
    #1;
    check("wrap_rd", 32'(sram_rd_addr), 12'h001);
    check("wrap_wr", 32'(sram_wr_addr), 12'h010);
    check("wrap_w", 32'(wmem_rd_addr), 12'h000);
    @(negedge clk);
    eng_busy = 1'b1;
    @(negedge clk);
    push(4'd13, 12'h000, 12'h000, 12'h000);
    eng_wr_en = 1'b1;
    #1;
    check("run_wr_en", 32'(sram_wr_en), 1);
    reset_b = 1'b0;
    #1;
    check("mid_rst_run", 32'(eng_run), 0);
    check("mid_rst_dvalid", 32'(done_valid), 0);
    check("mid_rst_id", 32'(done_id), 0);
    check("mid_rst_err", 32'(done_err), 0);
    check("mid_rst_jobs", 32'(jobs_done), 0);
    check("mid_rst_idle", 32'(sched_idle), 1);
    check("mid_rst_ready", 32'(cmd_ready), 1);
    check("mid_rst_reloc", 32'(sram_rd_addr), 12'h003);
    check("mid_rst_wr_en", 32'(sram_wr_en), 0);
    eng_busy = 1'b0;
    eng_wr_en = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (eng_run !== 1'b0) bad++;
    end
    check("queue_lost", bad, 0);
    check("post_rst_idle", 32'(sched_idle), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
